video_source_mux: RTL and testbench
===================================

VIDEO_SOURCE_MUX -- requirements
Module: video_source_mux

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- CHANNELS, 4, number of video sources.
- COLOR_WIDTH, 8, bits per colour component.
- SEL_WIDTH, 3, select width; must satisfy 2**SEL_WIDTH > CHANNELS.
- VS_POLARITY, 1'b0, active level of vs.
- HS_POLARITY, 1'b0, active level of hs.
- BLANK_FRAMES, 2, frames blanked per switch; must be 1..15.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, pixel clock; one clock, all logic on the rising edge.
- rst, in, 1, asynchronous active-high reset.
- ce, in, 1, clock enable; all registers hold when low.
- sel, in, SEL_WIDTH, asynchronous source request.
- in_r / in_g / in_b, in, CHANNELS*COLOR_WIDTH each, packed sources; channel i occupies [i*COLOR_WIDTH +: COLOR_WIDTH].
- in_hs / in_vs / in_de, in, 1 each, shared timing for all sources.
- r / g / b, out, COLOR_WIDTH each, registered output pixel.
- hs / vs / de, out, 1 each, registered timing.
- active_sel, out, SEL_WIDTH, source currently displayed.
- switching, out, 1, high while in PENDING or BLANK.

Function
REQ-003 sel SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value sel_s.
REQ-004 hs/vs/de SHALL equal in_hs/in_vs/in_de delayed by exactly 1 enabled cycle.
REQ-005 r/g/b SHALL be registered with the same 1-cycle latency, aligned with de.
REQ-006 frame_start SHALL be the cycle in_vs goes from !VS_POLARITY to VS_POLARITY, detected with a 1-cycle registered in_vs.
REQ-007 The state machine SHALL have states RUN, PENDING and BLANK.
REQ-008 RUN: output is channel active_sel. If sel_s != active_sel, go to PENDING and latch target = sel_s.
REQ-009 PENDING: output is still channel active_sel, and target tracks sel_s.
- If sel_s == active_sel, return to RUN with no switch.
- Else on frame_start, go to BLANK (macro defined) or load active_sel = target and go to RUN (macro undefined).
REQ-010 BLANK: output rgb is 0. The frame counter increments on each frame_start.
- When the count reaches BLANK_FRAMES, load active_sel = target, clear the counter and go to RUN.
- target stays frozen; sel_s changes during BLANK are evaluated in RUN afterwards.
REQ-011 active_sel SHALL change only on a frame_start cycle, so a displayed frame never mixes sources.
REQ-012 If active_sel >= CHANNELS, output rgb SHALL be 0 (black); timing still passes through.
REQ-013 Output rgb SHALL be 0 whenever the delayed de is 0.
REQ-014 A sel_s change on the same cycle as frame_start SHALL take effect at the next frame_start, not the current one.

Reset
REQ-015 While rst is high, outputs SHALL be: r/g/b = 0, de = 0, hs = !HS_POLARITY, vs = !VS_POLARITY, active_sel = 0, switching = 0.
REQ-016 While rst is high, state SHALL be RUN, counter 0, synchronizer stages 0, registered in_vs = !VS_POLARITY.
REQ-017 rst asserted mid-BLANK SHALL abort the switch; after release the block re-evaluates sel_s from RUN with active_sel = 0.
REQ-018 rst SHALL take effect regardless of ce.

Configuration
REQ-019 When VIDEO_SOURCE_MUX_BLANK_EN is defined:
- the BLANK state and frame counter SHALL exist, and switching SHALL be high during BLANK.
REQ-020 When VIDEO_SOURCE_MUX_BLANK_EN is undefined:
- the BLANK state, counter and BLANK_FRAMES logic SHALL be omitted;
- PENDING SHALL switch directly at frame_start with no black frame.

Verification
REQ-021 Reset then ce=1, sel=0, channel 0 constant 8'hAA: r/g/b = 8'hAA exactly 1 cycle after in_de rises; hs/vs/de delayed 1 cycle.
REQ-022 Macro on, BLANK_FRAMES=2, sel 0->2 mid-frame:
- output stays channel 0 until the next frame_start;
- then 2 full black frames with switching=1;
- channel 2 appears from the third frame_start, active_sel = 2.
REQ-023 sel 0->1->0 within one frame (PENDING): the state returns to RUN, no black frame, active_sel stays 0.
REQ-024 sel=5 with CHANNELS=4: after the switch completes, active_sel = 5, rgb = 0, timing passes unchanged.
REQ-025 rst pulse during BLANK: outputs reach reset values asynchronously, and after release active_sel = 0.
REQ-026 ce=0 for 10 cycles mid-frame: all outputs hold, and frame_start is not detected while ce is low.

Source files
------------

// File: rtl/video_source_mux.sv
// Frame-synchronous video source selector: switches the displayed source only at frame start.
// Optional black-frame insertion on a switch is enabled by defining VIDEO_SOURCE_MUX_BLANK_EN.
module video_source_mux #(
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned COLOR_WIDTH  = 8,
    parameter int unsigned SEL_WIDTH    = 3,
    parameter logic        VS_POLARITY  = 1'b0,
    parameter logic        HS_POLARITY  = 1'b0,
    parameter int unsigned BLANK_FRAMES = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            ce,
    input  logic [SEL_WIDTH-1:0]            sel,
    input  logic [CHANNELS*COLOR_WIDTH-1:0] in_r,
    input  logic [CHANNELS*COLOR_WIDTH-1:0] in_g,
    input  logic [CHANNELS*COLOR_WIDTH-1:0] in_b,
    input  logic                            in_hs,
    input  logic                            in_vs,
    input  logic                            in_de,
    output logic [COLOR_WIDTH-1:0]          r,
    output logic [COLOR_WIDTH-1:0]          g,
    output logic [COLOR_WIDTH-1:0]          b,
    output logic                            hs,
    output logic                            vs,
    output logic                            de,
    output logic [SEL_WIDTH-1:0]            active_sel,
    output logic                            switching
);

    localparam int unsigned CNT_W = 4;

    // Elaboration-time parameter sanity checks
    if ((BLANK_FRAMES < 1) || (BLANK_FRAMES > 15)) begin : g_bad_blank_frames
        $error("BLANK_FRAMES must be in 1..15");
    end
    if ((2 ** SEL_WIDTH) <= CHANNELS) begin : g_bad_sel_width
        $error("SEL_WIDTH too small for CHANNELS");
    end

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PENDING = 2'd1
`ifdef VIDEO_SOURCE_MUX_BLANK_EN
        ,ST_BLANK  = 2'd2
`endif
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [SEL_WIDTH-1:0]    r_sel_m;
    logic [SEL_WIDTH-1:0]    r_sel_s;
    logic [SEL_WIDTH-1:0]    r_target;
    logic [SEL_WIDTH-1:0]    w_target_next;
    logic [SEL_WIDTH-1:0]    r_active_sel;
    logic [SEL_WIDTH-1:0]    w_active_next;
    logic                    r_switching;
    logic                    r_vs_d;
    logic                    w_frame_start;
    logic                    w_blank;
    logic [COLOR_WIDTH-1:0]  w_r;
    logic [COLOR_WIDTH-1:0]  w_g;
    logic [COLOR_WIDTH-1:0]  w_b;
    logic [COLOR_WIDTH-1:0]  r_r;
    logic [COLOR_WIDTH-1:0]  r_g;
    logic [COLOR_WIDTH-1:0]  r_b;
    logic                    r_hs;
    logic                    r_vs;
    logic                    r_de;
`ifdef VIDEO_SOURCE_MUX_BLANK_EN
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_next;
    logic [CNT_W-1:0]        w_cnt_inc;

    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_blank   = (r_state == ST_BLANK);
`else
    assign w_blank   = 1'b0;
`endif

    assign w_frame_start = (in_vs == VS_POLARITY) && (r_vs_d != VS_POLARITY);

    // Source select synchronizer and vs edge history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel_m <= '0;
            r_sel_s <= '0;
            r_vs_d  <= ~VS_POLARITY;
        end else if (ce) begin
            r_sel_m <= sel;
            r_sel_s <= r_sel_m;
            r_vs_d  <= in_vs;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_target     <= '0;
            r_active_sel <= '0;
            r_switching  <= 1'b0;
`ifdef VIDEO_SOURCE_MUX_BLANK_EN
            r_cnt        <= '0;
`endif
        end else if (ce) begin
            r_state      <= w_state_next;
            r_target     <= w_target_next;
            r_active_sel <= w_active_next;
            r_switching  <= (w_state_next != ST_RUN);
`ifdef VIDEO_SOURCE_MUX_BLANK_EN
            r_cnt        <= w_cnt_next;
`endif
        end
    end

    // Next state; target is frozen at frame start so a same-cycle sel change waits a frame
    always_comb begin
        w_state_next  = r_state;
        w_target_next = r_target;
        w_active_next = r_active_sel;
`ifdef VIDEO_SOURCE_MUX_BLANK_EN
        w_cnt_next    = r_cnt;
`endif
        case (r_state)
            ST_RUN: begin
                if (r_sel_s != r_active_sel) begin
                    w_state_next  = ST_PENDING;
                    w_target_next = r_sel_s;
                end
            end
            ST_PENDING: begin
                if (r_sel_s == r_active_sel) begin
                    w_state_next  = ST_RUN;
                    w_target_next = r_sel_s;
                end else if (w_frame_start) begin
`ifdef VIDEO_SOURCE_MUX_BLANK_EN
                    w_state_next  = ST_BLANK;
                    w_cnt_next    = '0;
`else
                    w_state_next  = ST_RUN;
                    w_active_next = r_target;
`endif
                end else begin
                    w_target_next = r_sel_s;
                end
            end
`ifdef VIDEO_SOURCE_MUX_BLANK_EN
            ST_BLANK: begin
                if (w_frame_start) begin
                    if (w_cnt_inc == CNT_W'(BLANK_FRAMES)) begin
                        w_state_next  = ST_RUN;
                        w_active_next = r_target;
                        w_cnt_next    = '0;
                    end else begin
                        w_cnt_next    = w_cnt_inc;
                    end
                end
            end
`endif
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    // Channel mux; out-of-range selections fall through to black
    always_comb begin
        w_r = '0;
        w_g = '0;
        w_b = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (r_active_sel == SEL_WIDTH'(i)) begin
                w_r = in_r[i*COLOR_WIDTH +: COLOR_WIDTH];
                w_g = in_g[i*COLOR_WIDTH +: COLOR_WIDTH];
                w_b = in_b[i*COLOR_WIDTH +: COLOR_WIDTH];
            end
        end
    end

    // Output pixel and timing registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_r  <= '0;
            r_g  <= '0;
            r_b  <= '0;
            r_hs <= ~HS_POLARITY;
            r_vs <= ~VS_POLARITY;
            r_de <= 1'b0;
        end else if (ce) begin
            r_r  <= (in_de && !w_blank) ? w_r : '0;
            r_g  <= (in_de && !w_blank) ? w_g : '0;
            r_b  <= (in_de && !w_blank) ? w_b : '0;
            r_hs <= in_hs;
            r_vs <= in_vs;
            r_de <= in_de;
        end
    end

    assign r          = r_r;
    assign g          = r_g;
    assign b          = r_b;
    assign hs         = r_hs;
    assign vs         = r_vs;
    assign de         = r_de;
    assign active_sel = r_active_sel;
    assign switching  = r_switching;

endmodule

// File: tb/tb_video_source_mux.sv
// Scoreboard bench for video_source_mux: frame-level reference model, randomized sel/pixels/ce/reset.
module tb_video_source_mux;

    localparam int unsigned CH  = 4;
    localparam int unsigned CW  = 8;
    localparam int unsigned SW  = 3;
    localparam logic        VSP = 1'b0;
    localparam logic        HSP = 1'b0;
    localparam int unsigned BF  = 2;
    localparam int LINE_LEN = 16;
    localparam int LINES    = 6;
    localparam int FRAMES   = 48;

    typedef struct {
        logic [CW-1:0] r, g, b;
        logic          hs, vs, de;
        logic [SW-1:0] asel;
        logic          sw;
        logic          chk_sw;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ce = 1'b0;
    logic [SW-1:0]     sel = '0;
    logic [CH*CW-1:0]  in_r = '0, in_g = '0, in_b = '0;
    logic              in_hs = ~HSP, in_vs = ~VSP, in_de = 1'b0;
    logic [CW-1:0]     r, g, b;
    logic              hs, vs, de;
    logic [SW-1:0]     active_sel;
    logic              switching;

    int n_checks = 0;
    int n_errors = 0;

    exp_t sb_q[$];
    exp_t last_exp;
    exp_t mon_e;

    // Frame-level reference state
    int   m_active, m_target, m_cnt, cur_sel, sw_mask;
    bit   m_blank;
    logic m_prev_vs;

    video_source_mux #(
        .CHANNELS(CH), .COLOR_WIDTH(CW), .SEL_WIDTH(SW),
        .VS_POLARITY(VSP), .HS_POLARITY(HSP), .BLANK_FRAMES(BF)
    ) dut (
        .clk(clk), .rst(rst), .ce(ce), .sel(sel),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .in_hs(in_hs), .in_vs(in_vs), .in_de(in_de),
        .r(r), .g(g), .b(b), .hs(hs), .vs(vs), .de(de),
        .active_sel(active_sel), .switching(switching)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    function automatic exp_t reset_exp();
        exp_t e;
        e.r = '0; e.g = '0; e.b = '0;
        e.hs = ~HSP; e.vs = ~VSP; e.de = 1'b0;
        e.asel = '0; e.sw = 1'b0; e.chk_sw = 1'b1;
        return e;
    endfunction

    task automatic model_reset();
        m_active  = 0;
        m_target  = 0;
        m_cnt     = 0;
        m_blank   = 1'b0;
        m_prev_vs = ~VSP;
        sw_mask   = 5;
        last_exp  = reset_exp();
    endtask

    // Monitor: pops one expectation per clock and compares
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            n_checks++;
            if ({r, g, b, hs, vs, de, active_sel, (mon_e.chk_sw ? switching : 1'b0)} !==
                {mon_e.r, mon_e.g, mon_e.b, mon_e.hs, mon_e.vs, mon_e.de, mon_e.asel,
                 (mon_e.chk_sw ? mon_e.sw : 1'b0)}) begin
                n_errors++;
                $display("FAIL out @%0t got rgb=%h%h%h hs=%b vs=%b de=%b asel=%0d sw=%b want rgb=%h%h%h hs=%b vs=%b de=%b asel=%0d sw=%b (sw checked=%b)",
                         $time, r, g, b, hs, vs, de, active_sel, switching,
                         mon_e.r, mon_e.g, mon_e.b, mon_e.hs, mon_e.vs, mon_e.de,
                         mon_e.asel, mon_e.sw, mon_e.chk_sw);
            end
        end
    end

    // Drive one cycle and queue the expected registered response
    task automatic step(input bit en, input logic t_hs, input logic t_vs, input logic t_de);
        exp_t e;
        bit   fs;
        ce   = en;
        in_r = $urandom;
        in_g = $urandom;
        in_b = $urandom;
        if (en) begin
            in_hs = t_hs; in_vs = t_vs; in_de = t_de;
            e.hs = t_hs; e.vs = t_vs; e.de = t_de;
            if (t_de && !m_blank && (m_active < CH)) begin
                e.r = in_r[m_active*CW +: CW];
                e.g = in_g[m_active*CW +: CW];
                e.b = in_b[m_active*CW +: CW];
            end else begin
                e.r = '0; e.g = '0; e.b = '0;
            end
            fs = (t_vs == VSP) && (m_prev_vs != VSP);
            m_prev_vs = t_vs;
            if (fs) begin
                if (sw_mask < 3) sw_mask = 3;
                if (m_blank) begin
                    m_cnt++;
                    if (m_cnt == BF) begin
                        m_active = m_target;
                        m_blank  = 1'b0;
                        m_cnt    = 0;
                    end
                end else if (cur_sel != m_active) begin
`ifdef VIDEO_SOURCE_MUX_BLANK_EN
                    m_blank  = 1'b1;
                    m_target = cur_sel;
                    m_cnt    = 0;
`else
                    m_active = cur_sel;
`endif
                end
            end
            e.asel   = SW'(m_active);
            e.sw     = m_blank || (cur_sel != m_active);
            e.chk_sw = (sw_mask == 0);
            if (sw_mask > 0) sw_mask--;
        end else begin
            in_hs = 1'($urandom);
            in_vs = 1'($urandom);
            in_de = 1'($urandom);
            e = last_exp;
        end
        sb_q.push_back(e);
        last_exp = e;
        @(negedge clk);
    endtask

    task automatic set_sel(input int v);
        cur_sel = v;
        sel     = SW'(v);
        sw_mask = 5;
    endtask

    task automatic check_reset_values(input string tag);
        n_checks++;
        if ({r, g, b, de, hs, vs, active_sel, switching} !==
            {CW'(0), CW'(0), CW'(0), 1'b0, ~HSP, ~VSP, SW'(0), 1'b0}) begin
            n_errors++;
            $display("FAIL %s got rgb=%h%h%h de=%b hs=%b vs=%b asel=%0d sw=%b want zeros, hs=%b vs=%b",
                     tag, r, g, b, de, hs, vs, active_sel, switching, ~HSP, ~VSP);
        end
    endtask

    // Asynchronous reset pulse applied between clock edges
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("async_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    int plan_sel [16] = '{-1, 2, -1, -1, -1, -1, 1, 5, -1, -1, -1, 0, 3, -1, -1, -1};

    initial begin
        int   p_sel, prev_sel;
        bit   p_cancel, p_ce, p_rst;
        logic t_hs, t_vs, t_de;
        cur_sel = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_values("reset_hold");
        rst = 1'b0;
        model_reset();
        for (int f = 0; f < FRAMES; f++) begin
            if (f < 16) begin
                p_sel    = plan_sel[f];
                p_cancel = (f == 6);
                p_ce     = (f == 11) || (f == 3);
                p_rst    = (f == 13);
            end else begin
                p_sel    = ($urandom_range(1, 0) == 1) ? int'($urandom_range(5, 0)) : -1;
                p_cancel = ($urandom_range(3, 0) == 0);
                p_ce     = ($urandom_range(3, 0) == 0);
                p_rst    = ($urandom_range(7, 0) == 0);
            end
            prev_sel = cur_sel;
            for (int ln = 0; ln < LINES; ln++) begin
                for (int col = 0; col < LINE_LEN; col++) begin
                    if (ln == 2 && col == 0 && p_sel >= 0) set_sel(p_sel);
                    if (ln == 4 && col == 0 && p_cancel && p_sel >= 0) set_sel(prev_sel);
                    if (ln == 3 && col == 4 && p_ce) begin
                        for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
                    end
                    if (ln == 3 && col == 8 && p_rst) do_reset();
                    t_vs = (ln == 0) ? VSP : ~VSP;
                    t_hs = (col >= 13) ? HSP : ~HSP;
                    t_de = (ln != 0) && (col < 10);
                    step(1'b1, t_hs, t_vs, t_de);
                end
            end
        end
        step(1'b1, ~HSP, ~VSP, 1'b0);
        @(negedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain got %0d pending entries want 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
